// File: rtl/common_pkg.sv
// Shared types and constants for the instruction fetch unit.
package common_pkg;
  typedef enum logic [1:0] {IFU_IDLE, IFU_REQ_HI, IFU_REQ_LO, IFU_HOLD} ifu_state_t;
  localparam logic [15:0] IFU_NOP_INSTR = 16'h0000;
  localparam int          IFU_TIMEOUT_W = 8;
endpackage

// File: rtl/ifu_timeout_counter.sv
// Per-byte ack wait counter; used only when IFU_BUS_TIMEOUT_EN is defined.
module ifu_timeout_counter
  import common_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [IFU_TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)    cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + 1'b1;
  end

  // Fires on the LIMIT-th consecutive cycle without ack.
  assign expired = enable && (cnt_q == IFU_TIMEOUT_W'(LIMIT - 1));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches a 16-bit big-endian instruction as two byte reads, then hands it to the decoder.
// Optional bus timeout enabled by defining IFU_BUS_TIMEOUT_EN.
module instruction_fetch_unit
  import common_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  fetch_req_in,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_ack_in,
  input  logic [7:0]            mem_rdata_in,
  output logic [15:0]           instr_out,
  output logic                  instr_valid_out,
  input  logic                  instr_ready_in,
  output logic                  busy_out,
  output logic                  fetch_err_out
);
  ifu_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_d;
  logic [15:0]           instr_d;
  logic                  accept, tmo;
  logic                  unused_pc0;

  assign unused_pc0 = pc_in[0];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    instr_d = instr_out;
    accept  = 1'b0;
    case (state_q)
      IFU_IDLE: accept = fetch_req_in;
      IFU_REQ_HI:
        if (mem_ack_in) begin
          instr_d[15:8] = mem_rdata_in;
          state_d       = IFU_REQ_LO;
        end else if (tmo) begin
          instr_d = IFU_NOP_INSTR;
          state_d = IFU_HOLD;
        end
      IFU_REQ_LO:
        if (mem_ack_in) begin
          instr_d[7:0] = mem_rdata_in;
          state_d      = IFU_HOLD;
        end else if (tmo) begin
          instr_d = IFU_NOP_INSTR;
          state_d = IFU_HOLD;
        end
      IFU_HOLD:
        if (instr_ready_in) begin
          accept  = fetch_req_in;
          state_d = IFU_IDLE;
        end
      default: state_d = IFU_IDLE;
    endcase
    // A new fetch overrides the IDLE return, giving back-to-back fetches.
    if (accept) begin
      base_d  = {pc_in[ADDR_WIDTH-1:1], 1'b0};
      state_d = IFU_REQ_HI;
    end
  end

  always_comb begin
    addr_d = mem_addr_out;
    if (state_d == IFU_REQ_HI)      addr_d = base_d;
    else if (state_d == IFU_REQ_LO) addr_d = {base_d[ADDR_WIDTH-1:1], 1'b1};
  end

  // Outputs are registered from the next state so they are pure Moore.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q         <= IFU_IDLE;
      base_q          <= '0;
      instr_out       <= 16'h0000;
      mem_req_out     <= 1'b0;
      mem_addr_out    <= '0;
      instr_valid_out <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      instr_out       <= instr_d;
      mem_req_out     <= (state_d == IFU_REQ_HI) || (state_d == IFU_REQ_LO);
      mem_addr_out    <= addr_d;
      instr_valid_out <= (state_d == IFU_HOLD);
      busy_out        <= (state_d != IFU_IDLE);
    end
  end

`ifdef IFU_BUS_TIMEOUT_EN
  logic in_req, tmo_clear, fetch_err_q;

  assign in_req    = (state_q == IFU_REQ_HI) || (state_q == IFU_REQ_LO);
  assign tmo_clear = (state_d != state_q) &&
                     ((state_d == IFU_REQ_HI) || (state_d == IFU_REQ_LO));

  ifu_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clear    (tmo_clear),
    .enable   (in_req && !mem_ack_in),
    .expired  (tmo)
  );

  // Sticky until the next accepted fetch.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)    fetch_err_q <= 1'b0;
    else if (accept) fetch_err_q <= 1'b0;
    else if (tmo)    fetch_err_q <= 1'b1;
  end

  assign fetch_err_out = fetch_err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo           = 1'b0;
  assign fetch_err_out = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table, random fetches, reset corners.
module tb_instruction_fetch_unit;
  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [15:0] pc_in;
  logic        fetch_req_in;
  logic        mem_req_out;
  logic [15:0] mem_addr_out;
  logic        mem_ack_in;
  logic [7:0]  mem_rdata_in;
  logic [15:0] instr_out;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic        busy_out;
  logic        fetch_err_out;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .pc_in           (pc_in),
    .fetch_req_in    (fetch_req_in),
    .mem_req_out     (mem_req_out),
    .mem_addr_out    (mem_addr_out),
    .mem_ack_in      (mem_ack_in),
    .mem_rdata_in    (mem_rdata_in),
    .instr_out       (instr_out),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in),
    .busy_out        (busy_out),
    .fetch_err_out   (fetch_err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Launch a fetch (from IDLE, or from HOLD when b2b), serve both bytes with the
  // given ack delays, then sit in HOLD for hold cycles with ready low.
  task automatic fetch(input logic [15:0] pc, input logic [7:0] hi, input logic [7:0] lo,
                       input int whi, input int wlo, input int hold, input bit b2b,
                       input logic [15:0] exp_base, input logic [15:0] exp_instr);
    int req_cycles;
    int w;
    req_cycles   = 0;
    fetch_req_in = 1'b1;
    pc_in        = pc;
    if (b2b) instr_ready_in = 1'b1;
    @(negedge clk_in);
    fetch_req_in   = 1'b0;
    instr_ready_in = 1'b0;
    pc_in          = 16'($urandom);
    for (int ph = 0; ph < 2; ph++) begin
      w = (ph == 0) ? whi : wlo;
      for (int i = 0; i <= w; i++) begin
        if (mem_req_out) req_cycles++;
        check("addr", {16'h0, mem_addr_out}, (ph == 0) ? {16'h0, exp_base} : {16'h0, exp_base | 16'h1});
        check("valid_in_req", {31'h0, instr_valid_out}, 32'h0);
        mem_rdata_in = 8'($urandom);
        mem_ack_in   = (i == w);
        if (i == w) mem_rdata_in = (ph == 0) ? hi : lo;
        @(negedge clk_in);
        mem_ack_in = 1'b0;
      end
    end
    check("req_cycles", req_cycles, whi + wlo + 2);
    check("valid", {31'h0, instr_valid_out}, 32'h1);
    check("instr", {16'h0, instr_out}, {16'h0, exp_instr});
    check("req_in_hold", {31'h0, mem_req_out}, 32'h0);
    check("busy_in_hold", {31'h0, busy_out}, 32'h1);
    check("err", {31'h0, fetch_err_out}, 32'h0);
    for (int i = 0; i < hold; i++) begin
      fetch_req_in = 1'b1;
      pc_in        = 16'($urandom);
      @(negedge clk_in);
      fetch_req_in = 1'b0;
      check("hold_valid", {31'h0, instr_valid_out}, 32'h1);
      check("hold_instr", {16'h0, instr_out}, {16'h0, exp_instr});
    end
  endtask

  task automatic release_idle();
    instr_ready_in = 1'b1;
    @(negedge clk_in);
    instr_ready_in = 1'b0;
    check("rel_valid", {31'h0, instr_valid_out}, 32'h0);
    check("rel_busy", {31'h0, busy_out}, 32'h0);
    check("rel_req", {31'h0, mem_req_out}, 32'h0);
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  hi, lo;
    int          whi, wlo, hold;
    bit          b2b;
    logic [15:0] base, instr;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [15:0] rpc;
    logic [7:0]  rhi, rlo;
    bit          nb;

    vt[0] = '{16'h0010, 8'hA5, 8'h3C, 0, 0, 0, 1'b0, 16'h0010, 16'hA53C};
    vt[1] = '{16'h0021, 8'h12, 8'h34, 0, 0, 0, 1'b0, 16'h0020, 16'h1234};
    vt[2] = '{16'h1000, 8'hDE, 8'hAD, 4, 4, 5, 1'b0, 16'h1000, 16'hDEAD};
    vt[3] = '{16'h0040, 8'hBE, 8'hEF, 1, 2, 0, 1'b1, 16'h0040, 16'hBEEF};
    vt[4] = '{16'hFFFE, 8'h55, 8'hAA, 0, 3, 1, 1'b0, 16'hFFFE, 16'h55AA};
    vt[5] = '{16'hFFFF, 8'h01, 8'h80, 2, 0, 0, 1'b1, 16'hFFFE, 16'h0180};

    reset_in       = 1'b1;
    fetch_req_in   = 1'b1;
    pc_in          = 16'h0010;
    mem_ack_in     = 1'b0;
    mem_rdata_in   = 8'h00;
    instr_ready_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_req", {31'h0, mem_req_out}, 32'h0);
    check("rst_addr", {16'h0, mem_addr_out}, 32'h0);
    check("rst_instr", {16'h0, instr_out}, 32'h0);
    check("rst_valid", {31'h0, instr_valid_out}, 32'h0);
    check("rst_busy", {31'h0, busy_out}, 32'h0);
    check("rst_err", {31'h0, fetch_err_out}, 32'h0);
    fetch_req_in = 1'b0;
    reset_in     = 1'b0;
    @(negedge clk_in);

    for (int i = 0; i < 6; i++) begin
      fetch(vt[i].pc, vt[i].hi, vt[i].lo, vt[i].whi, vt[i].wlo, vt[i].hold, vt[i].b2b,
            vt[i].base, vt[i].instr);
      if (i == 5 || !vt[i+1].b2b) release_idle();
    end

    // Reference model: base is the pc with bit 0 cleared, instruction is {hi, lo}.
    nb = 1'b0;
    for (int it = 0; it < 24; it++) begin
      rpc = 16'($urandom);
      rhi = 8'($urandom);
      rlo = 8'($urandom);
      fetch(rpc, rhi, rlo, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), nb,
            rpc & 16'hFFFE, {rhi, rlo});
      nb = 1'($urandom_range(0, 1));
      if (!nb) release_idle();
    end
    if (nb) release_idle();

    // Reset while waiting on the low byte.
    fetch_req_in = 1'b1;
    pc_in        = 16'h0300;
    @(negedge clk_in);
    fetch_req_in = 1'b0;
    mem_ack_in   = 1'b1;
    mem_rdata_in = 8'h99;
    @(negedge clk_in);
    mem_ack_in = 1'b0;
    check("pre_rst_req", {31'h0, mem_req_out}, 32'h1);
    check("pre_rst_addr", {16'h0, mem_addr_out}, 32'h0301);
    #2 reset_in = 1'b1;
    #1;
    check("async_rst_req", {31'h0, mem_req_out}, 32'h0);
    check("async_rst_busy", {31'h0, busy_out}, 32'h0);
    check("async_rst_instr", {16'h0, instr_out}, 32'h0);
    @(negedge clk_in);
    reset_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_valid", {31'h0, instr_valid_out}, 32'h0);

    // Stray ack in IDLE must be ignored.
    mem_ack_in   = 1'b1;
    mem_rdata_in = 8'h77;
    @(negedge clk_in);
    mem_ack_in = 1'b0;
    @(negedge clk_in);
    check("stray_busy", {31'h0, busy_out}, 32'h0);
    check("stray_req", {31'h0, mem_req_out}, 32'h0);
    check("stray_valid", {31'h0, instr_valid_out}, 32'h0);
    check("stray_instr", {16'h0, instr_out}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
